// File: rtl/layer_sequencer_pkg.sv
// Shared definitions for the fully-connected layer sequencer: FSM state
// encoding and the width of the neuron configuration word.
package layer_sequencer_pkg;

  localparam int CFG_WORD_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CFG   = 3'd1,
    ST_FILL  = 3'd2,
    ST_BURST = 3'd3,
    ST_WAIT  = 3'd4,
    ST_DRAIN = 3'd5
  } state_e;

endpackage

// File: rtl/layer_sequencer_input_buffer.sv
// Holds one complete input vector: written in arrival order, then read back
// sequentially one sample per cycle while the burst is being replayed.
module seq_input_buffer #(
  parameter int NUM_WEIGHT = 5,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic                  wr_last,
  output logic                  rd_last,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int PW = (NUM_WEIGHT > 1) ? $clog2(NUM_WEIGHT) : 1;

  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0] mem_q [NUM_WEIGHT];
  logic [DATA_WIDTH-1:0] mem_d [NUM_WEIGHT];

  assign wr_last = (wr_ptr_q == PW'(NUM_WEIGHT - 1));
  assign rd_last = (rd_ptr_q == PW'(NUM_WEIGHT - 1));
  assign rd_data = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (wr_en) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_last ? '0 : wr_ptr_q + 1'b1;
    end
    if (rd_en) begin
      rd_ptr_d = rd_last ? '0 : rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Sample storage carries no reset; it is always written before being read.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/layer_sequencer.sv
// Sequencer for one fully-connected layer: streams configuration words to the
// neuron array, then buffers, replays and collects one inference per vector.
module layer_sequencer
  import layer_sequencer_pkg::*;
#(
  parameter int LAYER_NO   = 0,
  parameter int NUM_NEURON = 4,
  parameter int NUM_WEIGHT = 5,
  parameter int DATA_WIDTH = 16,
  parameter int PRETRAINED = 0,
  parameter int TIMEOUT    = 64
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             cfg_valid,
  output logic                             cfg_ready,
  input  logic [CFG_WORD_W-1:0]            cfg_data,
  output logic                             weightValid,
  output logic                             biasValid,
  output logic [DATA_WIDTH-1:0]            weightValue,
  output logic [CFG_WORD_W-1:0]            biasValue,
  output logic [CFG_WORD_W-1:0]            config_layer_num,
  output logic [CFG_WORD_W-1:0]            config_neuron_num,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [DATA_WIDTH-1:0]            in_data,
  output logic [DATA_WIDTH-1:0]            nrn_input,
  output logic                             nrn_input_valid,
  input  logic [NUM_NEURON*DATA_WIDTH-1:0] nrn_out,
  input  logic [NUM_NEURON-1:0]            nrn_outvalid,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic                             out_last,
  output logic                             cfg_done,
  output logic                             error
);

  localparam int WCW = $clog2(NUM_WEIGHT + 1);
  localparam int NCW = $clog2(NUM_NEURON + 1);
  localparam int IW  = (NUM_NEURON > 1) ? $clog2(NUM_NEURON) : 1;
  localparam int TCW = $clog2(TIMEOUT + 1);

  state_e                  state_q, state_d;
  logic [WCW-1:0]          w_cnt_q, w_cnt_d;
  logic [NCW-1:0]          n_cnt_q, n_cnt_d;
  logic [NCW-1:0]          cfg_nrn_q, cfg_nrn_d;
  logic [IW-1:0]           out_idx_q, out_idx_d;
  logic [TCW-1:0]          wait_cnt_q, wait_cnt_d;
  logic [NUM_NEURON-1:0]   mask_q, mask_d;
  logic                    weight_valid_q, weight_valid_d;
  logic                    bias_valid_q, bias_valid_d;
  logic [DATA_WIDTH-1:0]   weight_value_q, weight_value_d;
  logic [CFG_WORD_W-1:0]   bias_value_q, bias_value_d;
  logic                    cfg_last_q, cfg_last_d;
  logic                    cfg_done_q, cfg_done_d;
  logic                    error_q, error_d;
  logic [DATA_WIDTH-1:0]   res_q [NUM_NEURON];
  logic [DATA_WIDTH-1:0]   res_d [NUM_NEURON];

  logic                    cfg_req, cfg_acc, in_acc, is_bias;
  logic                    buf_wr_last, buf_rd_last;
  logic [DATA_WIDTH-1:0]   buf_rd_data;

  seq_input_buffer #(
    .NUM_WEIGHT (NUM_WEIGHT),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (in_acc),
    .wr_data (in_data),
    .rd_en   (state_q == ST_BURST),
    .wr_last (buf_wr_last),
    .rd_last (buf_rd_last),
    .rd_data (buf_rd_data)
  );

  // A ROM-backed layer never opens the configuration path.
  assign cfg_req   = cfg_valid && (PRETRAINED == 0);
  assign cfg_ready = (state_q == ST_CFG);
  assign in_ready  = (state_q == ST_FILL) ||
                     ((state_q == ST_IDLE) && cfg_done_q && !cfg_req);
  assign cfg_acc   = cfg_valid && cfg_ready;
  assign in_acc    = in_valid && in_ready;
  assign is_bias   = (w_cnt_q == WCW'(NUM_WEIGHT));

  assign weightValid       = weight_valid_q;
  assign biasValid         = bias_valid_q;
  assign weightValue       = weight_value_q;
  assign biasValue         = bias_value_q;
  assign config_layer_num  = CFG_WORD_W'(LAYER_NO);
  assign config_neuron_num = CFG_WORD_W'(cfg_nrn_q);
  assign cfg_done          = cfg_done_q;
  assign error             = error_q;

  assign nrn_input_valid = (state_q == ST_BURST);
  assign nrn_input       = nrn_input_valid ? buf_rd_data : '0;
  assign out_valid       = (state_q == ST_DRAIN);
  assign out_data        = out_valid ? res_q[out_idx_q] : '0;
  assign out_last        = out_valid && (out_idx_q == IW'(NUM_NEURON - 1));

  always_comb begin
    state_d        = state_q;
    w_cnt_d        = w_cnt_q;
    n_cnt_d        = n_cnt_q;
    cfg_nrn_d      = cfg_nrn_q;
    out_idx_d      = out_idx_q;
    wait_cnt_d     = wait_cnt_q;
    mask_d         = mask_q;
    weight_valid_d = 1'b0;
    bias_valid_d   = 1'b0;
    weight_value_d = weight_value_q;
    bias_value_d   = bias_value_q;
    cfg_last_d     = 1'b0;
    cfg_done_d     = cfg_done_q || cfg_last_q;
    error_d        = error_q;
    res_d          = res_q;

    case (state_q)
      ST_IDLE: begin
        if (cfg_req)     state_d = ST_CFG;
        else if (in_acc) state_d = ST_FILL;
      end
      ST_CFG: begin
        if (cfg_acc) begin
          cfg_nrn_d = n_cnt_q;
          if (is_bias) begin
            bias_valid_d = 1'b1;
            bias_value_d = cfg_data;
            w_cnt_d      = '0;
            if (n_cnt_q == NCW'(NUM_NEURON - 1)) begin
              n_cnt_d    = '0;
              cfg_last_d = 1'b1;
              state_d    = ST_IDLE;
            end else begin
              n_cnt_d = n_cnt_q + 1'b1;
            end
          end else begin
            weight_valid_d = 1'b1;
            weight_value_d = cfg_data[DATA_WIDTH-1:0];
            w_cnt_d        = w_cnt_q + 1'b1;
          end
        end
      end
      ST_FILL: begin
        if (in_acc && buf_wr_last) state_d = ST_BURST;
      end
      ST_BURST: begin
        if (buf_rd_last) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        mask_d = mask_q | nrn_outvalid;
        for (int k = 0; k < NUM_NEURON; k++) begin
          if (nrn_outvalid[k]) res_d[k] = nrn_out[k*DATA_WIDTH +: DATA_WIDTH];
        end
        // Completion is judged on the mask including this cycle's strobes.
        if (&mask_d) begin
          state_d    = ST_DRAIN;
          mask_d     = '0;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == TCW'(TIMEOUT - 1)) begin
          error_d    = 1'b1;
          state_d    = ST_IDLE;
          mask_d     = '0;
          wait_cnt_d = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (out_ready) begin
          if (out_last) begin
            out_idx_d = '0;
            state_d   = ST_IDLE;
          end else begin
            out_idx_d = out_idx_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      w_cnt_q        <= '0;
      n_cnt_q        <= '0;
      cfg_nrn_q      <= '0;
      out_idx_q      <= '0;
      wait_cnt_q     <= '0;
      mask_q         <= '0;
      weight_valid_q <= 1'b0;
      bias_valid_q   <= 1'b0;
      weight_value_q <= '0;
      bias_value_q   <= '0;
      cfg_last_q     <= 1'b0;
      cfg_done_q     <= (PRETRAINED != 0);
      error_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      w_cnt_q        <= w_cnt_d;
      n_cnt_q        <= n_cnt_d;
      cfg_nrn_q      <= cfg_nrn_d;
      out_idx_q      <= out_idx_d;
      wait_cnt_q     <= wait_cnt_d;
      mask_q         <= mask_d;
      weight_valid_q <= weight_valid_d;
      bias_valid_q   <= bias_valid_d;
      weight_value_q <= weight_value_d;
      bias_value_q   <= bias_value_d;
      cfg_last_q     <= cfg_last_d;
      cfg_done_q     <= cfg_done_d;
      error_q        <= error_d;
    end
  end

  // Result bank is pure data; it is only visible through the gated drain mux.
  always_ff @(posedge clk) begin
    res_q <= res_d;
  end

endmodule

// File: tb/tb_layer_sequencer.sv
// Self-checking bench for layer_sequencer: table-driven configuration stream,
// hand-written inference corner cases and randomized vectors against a model.
module tb_layer_sequencer;

  localparam int NN  = 4;
  localparam int NW  = 5;
  localparam int DW  = 16;
  localparam int TO  = 64;
  localparam int LNO = 3;
  localparam int NC  = NN * (NW + 1);

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cfg_valid = 1'b0;
  logic              cfg_ready;
  logic [31:0]       cfg_data = '0;
  logic              weightValid, biasValid;
  logic [DW-1:0]     weightValue;
  logic [31:0]       biasValue, config_layer_num, config_neuron_num;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DW-1:0]     in_data = '0;
  logic [DW-1:0]     nrn_input;
  logic              nrn_input_valid;
  logic [NN*DW-1:0]  nrn_out = '0;
  logic [NN-1:0]     nrn_outvalid = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DW-1:0]     out_data;
  logic              out_last, cfg_done, error;

  always #5 clk = ~clk;

  layer_sequencer #(
    .LAYER_NO(LNO), .NUM_NEURON(NN), .NUM_WEIGHT(NW),
    .DATA_WIDTH(DW), .PRETRAINED(0), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_data(cfg_data),
    .weightValid(weightValid), .biasValid(biasValid),
    .weightValue(weightValue), .biasValue(biasValue),
    .config_layer_num(config_layer_num), .config_neuron_num(config_neuron_num),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .nrn_input(nrn_input), .nrn_input_valid(nrn_input_valid),
    .nrn_out(nrn_out), .nrn_outvalid(nrn_outvalid),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last),
    .cfg_done(cfg_done), .error(error)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  typedef struct {
    logic [31:0] data;
    logic        wv;
    logic        bv;
    logic [31:0] nrn;
  } cfg_rec_t;

  cfg_rec_t       ctab [NC];
  logic [DW-1:0]  vec [$];
  logic [DW-1:0]  obs [$];
  int             lat [NN];
  bit             dead [NN];
  int             bursts = 0;
  int             after  = 0;
  bit             prev_v = 1'b0;

  // Neuron k's result: position-weighted sum of the vector, so order matters.
  function automatic logic [DW-1:0] nref(input logic [DW-1:0] v[$], input int k);
    logic [31:0] acc;
    acc = '0;
    foreach (v[i]) acc = acc + 32'(v[i]) * 32'(i + 1 + k);
    return acc[DW-1:0];
  endfunction

  // Advance to the next negedge and update the neuron-array model.
  task automatic step();
    @(negedge clk);
    if (!rst_n) begin
      prev_v = 1'b0;
      after = 0;
      nrn_outvalid = '0;
      return;
    end
    if (nrn_input_valid) begin
      if (!prev_v) begin
        obs.delete();
        bursts++;
      end
      obs.push_back(nrn_input);
      after = 0;
    end else if (prev_v) begin
      after = 1;
    end else if (after > 0 && after < 1000) begin
      after++;
    end
    prev_v = nrn_input_valid;
    for (int k = 0; k < NN; k++) begin
      nrn_outvalid[k] = (after > 0) && (after == lat[k]) && !dead[k];
      nrn_out[k*DW +: DW] = nrn_outvalid[k] ? nref(obs, k) : DW'($urandom);
    end
  endtask

  task automatic do_config();
    int idx = 0;
    int pend = -1;
    bit prev_last = 1'b0;
    bit fin = 1'b0;
    int guard = 0;
    while (!fin && guard < 100) begin
      guard++;
      step();
      in_valid  = 1'b0;
      out_ready = 1'b0;
      cfg_valid = (idx < NC);
      cfg_data  = (idx < NC) ? ctab[idx].data : '0;
      #1;
      if (prev_last) begin
        chk("cfg_done_rise", {63'b0, cfg_done}, 64'd1);
        chk("cfg_idle_strobe", {62'b0, weightValid, biasValid}, 64'd0);
        fin = 1'b1;
      end else if (pend >= 0) begin
        chk($sformatf("cfg_strobe%0d", pend), {30'b0, weightValid, biasValid, config_neuron_num},
            {30'b0, ctab[pend].wv, ctab[pend].bv, ctab[pend].nrn});
        chk($sformatf("cfg_value%0d", pend),
            ctab[pend].wv ? {48'b0, weightValue} : {32'b0, biasValue},
            ctab[pend].wv ? {48'b0, ctab[pend].data[DW-1:0]} : {32'b0, ctab[pend].data});
        if (pend == NC - 1) chk("cfg_done_low_at_last", {63'b0, cfg_done}, 64'd0);
      end
      prev_last = (pend == NC - 1);
      pend = (cfg_valid && cfg_ready) ? idx : -1;
      if (pend >= 0) idx++;
    end
    if (!fin) chk("cfg_sequence_timeout", 64'(idx), 64'(NC));
  endtask

  task automatic feed(input int gap_mode);
    int gp [7] = '{1, 0, 1, 1, 0, 1, 1};
    int idx = 0;
    int p = 0;
    int guard = 0;
    while (idx < NW && guard < 300) begin
      guard++;
      step();
      cfg_valid = 1'b0;
      out_ready = 1'b0;
      case (gap_mode)
        0:       in_valid = 1'b1;
        1:       in_valid = (gp[p % 7] != 0);
        default: in_valid = ($urandom_range(0, 2) != 0);
      endcase
      in_data = vec[idx];
      #1;
      if (in_valid && in_ready) idx++;
      p++;
    end
    if (idx < NW) chk("feed_timeout", 64'(idx), 64'(NW));
  endtask

  task automatic collect(input int ready_mode);
    int rp4 [4] = '{1, 0, 0, 1};
    logic [DW-1:0] expv [NN];
    int n = 0;
    int rp = 0;
    int guard = 0;
    bit held = 1'b0;
    logic [DW:0] hv = '0;
    for (int k = 0; k < NN; k++) expv[k] = nref(vec, k);
    while (n < NN && guard < 400) begin
      guard++;
      step();
      in_valid  = 1'b0;
      cfg_valid = 1'b0;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (rp4[rp % 4] != 0);
        default: out_ready = ($urandom_range(0, 1) != 0);
      endcase
      #1;
      if (held) chk("drain_hold", {46'b0, out_valid, out_last, out_data}, {46'b0, 1'b1, hv});
      held = 1'b0;
      if (out_valid) begin
        rp++;
        if (out_ready) begin
          chk($sformatf("result%0d", n), {47'b0, out_last, out_data}, {47'b0, (n == NN - 1), expv[n]});
          n++;
        end else begin
          held = 1'b1;
          hv = {out_last, out_data};
        end
      end
    end
    if (n < NN) chk("collect_timeout", 64'(n), 64'(NN));
    step();
    out_ready = 1'b0;
    #1;
    chk("drain_end_idle", {61'b0, out_valid, in_ready, error}, {61'b0, 1'b0, 1'b1, 1'b0});
    chk("burst_count", 64'(bursts), 64'd1);
    chk("burst_len", 64'(obs.size()), 64'(NW));
    for (int i = 0; i < NW; i++) begin
      if (i < obs.size()) chk($sformatf("burst_sample%0d", i), {48'b0, obs[i]}, {48'b0, vec[i]});
    end
  endtask

  task automatic new_vector();
    vec.delete();
    for (int i = 0; i < NW; i++) vec.push_back(DW'($urandom));
    bursts = 0;
  endtask

  initial begin
    for (int j = 0; j < NC; j++) begin
      ctab[j].data = $urandom;
      ctab[j].wv   = ((j % (NW + 1)) < NW);
      ctab[j].bv   = ((j % (NW + 1)) == NW);
      ctab[j].nrn  = 32'(j / (NW + 1));
    end
    for (int k = 0; k < NN; k++) begin
      lat[k]  = k + 1;
      dead[k] = 1'b0;
    end

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("reset_ctrl", {55'b0, weightValid, biasValid, cfg_done, error, out_valid, out_last,
        nrn_input_valid, in_ready, cfg_ready}, 64'd0);
    chk("reset_layer_num", {32'b0, config_layer_num}, 64'(LNO));
    chk("reset_neuron_num", {32'b0, config_neuron_num}, 64'd0);
    chk("reset_values", {weightValue, biasValue, out_data}, 64'd0);
    chk("reset_nrn_input", {48'b0, nrn_input}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Input must be refused until the layer is configured
    step();
    in_valid = 1'b1;
    #1;
    chk("no_fill_before_cfg", {63'b0, in_ready}, 64'd0);
    in_valid = 1'b0;

    do_config();

    // Gapped input, staggered neuron latencies, stalled drain
    new_vector();
    lat = '{3, 5, 4, 6};
    feed(1);
    collect(1);

    repeat (6) begin
      new_vector();
      for (int k = 0; k < NN; k++) lat[k] = $urandom_range(1, 8);
      feed(2);
      collect(2);
    end

    // Neuron 2 never answers: timeout
    begin
      bit saw_ov = 1'b0;
      bit reached = 1'b0;
      int guard = 0;
      new_vector();
      lat = '{3, 5, 4, 6};
      dead[2] = 1'b1;
      feed(0);
      while (!reached && guard < 200) begin
        guard++;
        step();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        if (out_valid) saw_ov = 1'b1;
        if (after == TO) chk("err_before_timeout", {63'b0, error}, 64'd0);
        if (after == TO + 1) begin
          chk("err_after_timeout", {63'b0, error}, 64'd1);
          chk("idle_after_timeout", {62'b0, in_ready, out_valid}, 64'd2);
          reached = 1'b1;
        end
      end
      if (!reached) chk("timeout_not_reached", 64'(after), 64'(TO + 1));
      chk("no_out_valid_on_timeout", {63'b0, saw_ov}, 64'd0);
      dead[2] = 1'b0;
    end

    // Reset in the middle of a burst
    begin
      int bc = 0;
      int guard = 0;
      new_vector();
      feed(0);
      while (bc < 3 && guard < 50) begin
        guard++;
        step();
        in_valid = 1'b0;
        #1;
        if (nrn_input_valid) bc++;
      end
      if (bc < 3) chk("burst_not_seen", 64'(bc), 64'd3);
      #1;
      rst_n = 1'b0;
      #1;
      chk("reset_mid_burst", {60'b0, nrn_input_valid, cfg_done, error, out_valid}, 64'd0);
      step();
      rst_n = 1'b1;
      do_config();
      new_vector();
      for (int k = 0; k < NN; k++) lat[k] = $urandom_range(1, 8);
      feed(0);
      collect(0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_total);
    $fatal(1);
  end

endmodule
